// File: rtl/ps2_pkg.sv
// Shared PS/2 decoder definitions: scan codes, prefix bytes, key bit
// positions, receiver state encoding and the scan-code to key lookup.
package ps2_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = 8;
    localparam int unsigned IDX_W  = 3;

    // Prefix bytes
    localparam logic [BYTE_W-1:0] PFX_EXT = 8'hE0;
    localparam logic [BYTE_W-1:0] PFX_BRK = 8'hF0;

    // Make codes (first four need the E0 prefix)
    localparam logic [BYTE_W-1:0] SC_LEFT    = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_UP      = 8'h75;
    localparam logic [BYTE_W-1:0] SC_DOWN    = 8'h72;
    localparam logic [BYTE_W-1:0] SC_RIGHT   = 8'h74;
    localparam logic [BYTE_W-1:0] SC_RETRY   = 8'h2D;
    localparam logic [BYTE_W-1:0] SC_RETRACT = 8'h66;
    localparam logic [BYTE_W-1:0] SC_NEXT    = 8'h31;
    localparam logic [BYTE_W-1:0] SC_SWITCH  = 8'h29;

    // Key vector bit positions
    localparam logic [IDX_W-1:0] KEY_LEFT    = 3'd7;
    localparam logic [IDX_W-1:0] KEY_UP      = 3'd6;
    localparam logic [IDX_W-1:0] KEY_DOWN    = 3'd5;
    localparam logic [IDX_W-1:0] KEY_RIGHT   = 3'd4;
    localparam logic [IDX_W-1:0] KEY_RETRY   = 3'd3;
    localparam logic [IDX_W-1:0] KEY_RETRACT = 3'd2;
    localparam logic [IDX_W-1:0] KEY_NEXT    = 3'd1;
    localparam logic [IDX_W-1:0] KEY_SWITCH  = 3'd0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } key_map_t;

    // Scan code to key bit; arrow codes only hit when the E0 prefix was seen
    function automatic key_map_t map_code(input logic [BYTE_W-1:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b0;
        m.idx = '0;
        case (code)
            SC_LEFT:    begin m.hit = ext;  m.idx = KEY_LEFT;    end
            SC_UP:      begin m.hit = ext;  m.idx = KEY_UP;      end
            SC_DOWN:    begin m.hit = ext;  m.idx = KEY_DOWN;    end
            SC_RIGHT:   begin m.hit = ext;  m.idx = KEY_RIGHT;   end
            SC_RETRY:   begin m.hit = 1'b1; m.idx = KEY_RETRY;   end
            SC_RETRACT: begin m.hit = 1'b1; m.idx = KEY_RETRACT; end
            SC_NEXT:    begin m.hit = 1'b1; m.idx = KEY_NEXT;    end
            SC_SWITCH:  begin m.hit = 1'b1; m.idx = KEY_SWITCH;  end
            default:    begin m.hit = 1'b0; m.idx = '0;          end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises ps2_clk/ps2_data, glitch-filters the
// clock, shifts in start/8 data/parity/stop on filtered falling edges and
// abandons a frame that stalls for FRAME_TIMEOUT cycles.
// Ports: clk, rst_n (async active-low), ps2_clk, ps2_data (raw, async);
//        rx_byte (last good byte), rx_valid (1-cycle), rx_err (1-cycle).
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN    = 4,
    parameter int unsigned FRAME_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_valid,
    output logic              rx_err
);

    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TCW = $clog2(FRAME_TIMEOUT + 1);

    logic [1:0]        clk_sync;
    logic [1:0]        dat_sync;
    logic [FCW-1:0]    filt_cnt;
    logic              filt;
    logic              filt_d;
    rx_state_t         state, state_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [BYTE_W-1:0] shreg, shreg_nxt;
    logic              par_ok, par_ok_nxt;
    logic [TCW-1:0]    tmo_cnt, tmo_cnt_nxt;
    logic [BYTE_W-1:0] byte_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic              bit_evt_c;
    logic              dat_c;

    assign bit_evt_c = filt_d & ~filt;
    assign dat_c     = dat_sync[1];

    // Synchronisers and clock filter; bus idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt_cnt <= '0;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            filt_d   <= filt;
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_ok   <= 1'b0;
            tmo_cnt  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            par_ok   <= par_ok_nxt;
            tmo_cnt  <= tmo_cnt_nxt;
            rx_byte  <= byte_nxt;
            rx_valid <= valid_nxt;
            rx_err   <= err_nxt;
        end
    end

    // Frame next-state and outputs
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_ok_nxt  = par_ok;
        tmo_cnt_nxt = tmo_cnt;
        byte_nxt    = rx_byte;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if (bit_evt_c) begin
            tmo_cnt_nxt = '0;
            case (state)
                RX_IDLE: begin
                    if (!dat_c) begin
                        state_nxt   = RX_DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                RX_DATA: begin
                    shreg_nxt   = {dat_c, shreg[BYTE_W-1:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                end
                RX_PARITY: begin
                    par_ok_nxt = ^{shreg, dat_c};
                    state_nxt  = RX_STOP;
                end
                RX_STOP: begin
                    state_nxt = RX_IDLE;
                    if (dat_c && par_ok) begin
                        byte_nxt  = shreg;
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end else if (state == RX_IDLE) begin
            tmo_cnt_nxt = '0;
        end else if (tmo_cnt == TCW'(FRAME_TIMEOUT - 1)) begin
            tmo_cnt_nxt = '0;
            state_nxt   = RX_IDLE;
            err_nxt     = 1'b1;
        end else begin
            tmo_cnt_nxt = tmo_cnt + TCW'(1);
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard command decoder: receives scan bytes, tracks E0/F0 prefixes
// and a held-key vector, and pulses one key bit per accepted make code.
// Ports: clk, rst_n (async active-low), ps2_clk, ps2_data (raw, async);
//        key[7:0] {left,up,down,right,retry,retract,next,switch} pulses,
//        scan_valid, scan_code, frame_err.
// Build option: define PS2_TYPEMATIC_EN to pulse on every make, including
// auto-repeat of a held key.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN    = 4,
    parameter int unsigned FRAME_TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [KEY_W-1:0]  key,
    output logic              scan_valid,
    output logic [BYTE_W-1:0] scan_code,
    output logic              frame_err
);

    logic             ext, ext_nxt;
    logic             brk, brk_nxt;
    logic [KEY_W-1:0] held, held_nxt;
    logic [KEY_W-1:0] key_nxt;
    key_map_t         map_c;

    ps2_rx_frame #(
        .FILTER_LEN   (FILTER_LEN),
        .FRAME_TIMEOUT(FRAME_TIMEOUT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (scan_code),
        .rx_valid(scan_valid),
        .rx_err  (frame_err)
    );

    assign map_c = map_code(scan_code, ext);

    // Decoder state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            held <= '0;
            key  <= '0;
        end else begin
            ext  <= ext_nxt;
            brk  <= brk_nxt;
            held <= held_nxt;
            key  <= key_nxt;
        end
    end

    // Prefix tracking, held update and key pulse selection
    always_comb begin
        ext_nxt  = ext;
        brk_nxt  = brk;
        held_nxt = held;
        key_nxt  = '0;
        if (scan_valid) begin
            if (scan_code == PFX_EXT) begin
                ext_nxt = 1'b1;
            end else if (scan_code == PFX_BRK) begin
                brk_nxt = 1'b1;
            end else begin
                ext_nxt = 1'b0;
                brk_nxt = 1'b0;
                if (map_c.hit) begin
                    if (brk) begin
                        held_nxt[map_c.idx] = 1'b0;
                    end else begin
`ifdef PS2_TYPEMATIC_EN
                        key_nxt[map_c.idx]  = 1'b1;
`else
                        key_nxt[map_c.idx]  = ~held[map_c.idx];
`endif
                        held_nxt[map_c.idx] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL expose parameter FILTER_LEN, default 4: consecutive equal samples required before the filtered ps2_clk level changes.
REQ-002 SHALL expose parameter FRAME_TIMEOUT, default 50000: idle clk cycles mid-frame before the frame is abandoned.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1: raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1: raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port key, output, 8: one-cycle command pulses {left,up,down,right,retry,retract,next,switch}, bit 7 = left.
REQ-008 SHALL have port scan_valid, output, 1: one-cycle pulse per accepted byte.
REQ-009 SHALL have port scan_code, output, 8: last accepted byte, held until the next one.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a parity, start, stop or timeout failure.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two flops each, then filter ps2_clk per FILTER_LEN; a bit event is a filtered 1->0 transition.
REQ-012 SHALL run the receiver FSM IDLE->DATA(8 bits, LSB first)->PARITY->STOP->IDLE, sampling synchronised ps2_data on each bit event.
REQ-013 SHALL abandon any frame whose start bit is 1 and return to IDLE without a byte.
REQ-014 SHALL reject a frame with even parity over data+parity or stop bit 0: frame_err pulses, no scan_valid.
REQ-015 SHALL pulse frame_err and return to IDLE when FRAME_TIMEOUT cycles pass without a bit event outside IDLE; the timeout counter clears on every bit event.
REQ-016 SHALL assert scan_valid and update scan_code exactly 1 cycle after the STOP bit event of a good frame.
REQ-017 SHALL keep decoder flags ext (0xE0 seen) and brk (0xF0 seen); both clear after any non-prefix byte.
REQ-018 SHALL map make codes: E0 6B left, E0 75 up, E0 72 down, E0 74 right, 2D retry, 66 retract, 31 next, 29 switch; a non-extended 6B/75/72/74 maps to nothing.
REQ-019 SHALL pulse the mapped key bit exactly 1 cycle after scan_valid of the final make byte; at most one key bit is high in any cycle.
REQ-020 SHALL keep an 8-bit held vector: set on make, cleared on break (F0 or E0 F0 + code); a break produces no pulse.
REQ-021 SHALL ignore unmapped codes, leave held unchanged, and still clear the prefix flags.
REQ-022 SHALL ignore a break for a key that is not held.

Reset
REQ-023 SHALL, with rst_n low, force IDLE, bit counter 0, timeout 0, ext=brk=0, held=0, key=0, scan_valid=0, scan_code=8'h00, frame_err=0, filter state=1.
REQ-024 SHALL, on reset assertion mid-frame, discard the partial byte; after release, the first byte is decoded without prefix state.

Configuration
REQ-025 SHALL honour macro PS2_TYPEMATIC_EN: when defined, every make code, including repeats while held, pulses its key.
REQ-026 SHALL, without PS2_TYPEMATIC_EN, pulse a key only when its held bit was 0 before that make, suppressing auto-repeat.

Structure
REQ-027 SHALL take the scan-code constants, the E0/F0 prefix constants, key bit indices and the receiver state encoding from shared package ps2_pkg.
REQ-028 SHALL instantiate sub-module ps2_rx_frame (sync, filter, frame FSM, timeout), which outputs byte/valid/err; mapping and held logic stay in the top level.

Verification
REQ-029 SHALL cover: frame 0x29, correct odd parity -> scan_valid and scan_code=8'h29, then next cycle key=8'b0000_0001.
REQ-030 SHALL cover: E0 6B, then E0 F0 6B -> exactly one key[7] pulse; held[7] ends at 0; no pulse on the break.
REQ-031 SHALL cover: 0x2D with the parity bit flipped -> frame_err pulse, no scan_valid, key stays 0.
REQ-032 SHALL cover: 4 data bits, then idle for FRAME_TIMEOUT cycles -> frame_err pulse; next good frame 0x31 -> key[1] pulse.
REQ-033 SHALL cover: 66, 66, 66 without a break -> one key[2] pulse with the macro undefined and three pulses with PS2_TYPEMATIC_EN.
REQ-034 SHALL cover: rst_n low after E0 is received, then 75 -> no up pulse and no key pulse; scan_code=8'h75.
